// File: rtl/aes_key_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// aes_key_scheduler_pkg
// Shared definitions for the AES-128 key scheduler: FSM state encoding,
// schedule geometry, round-constant parameters, requester IDs and the
// GF(2^8) arithmetic helpers used by the scheduler and its S-box.
// -----------------------------------------------------------------------------
package aes_key_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXP   = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam int NR = 10;  // rounds
  localparam int NK = 4;   // key words
  localparam int NW = 44;  // expanded words

  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] GF_RED    = 8'h1b;

  localparam logic ENC = 1'b0;
  localparam logic DEC = 1'b1;

  // Multiply by x in GF(2^8) with the AES reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    if (a[7]) begin
      return {a[6:0], 1'b0} ^ GF_RED;
    end else begin
      return {a[6:0], 1'b0};
    end
  endfunction

  // General GF(2^8) multiply, shift-and-add.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) begin
        p = p ^ x;
      end else begin
        p = p;
      end
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box: multiplicative inverse in GF(2^8)
// followed by the AES affine transform.
//   i_byte  in  8  input byte
//   o_byte  out 8  substituted byte
// -----------------------------------------------------------------------------
module aes_sbox
  import aes_key_scheduler_pkg::*;
(
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  logic [7:0] w_sq;
  logic [7:0] w_inv;

  // Inverse as a^254 = a^2 * a^4 * ... * a^128 (maps 0 to 0), then affine map.
  always_comb begin
    w_sq  = i_byte;
    w_inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      w_sq  = gf_mul(w_sq, w_sq);
      w_inv = gf_mul(w_inv, w_sq);
    end
    o_byte = w_inv
           ^ {w_inv[6:0], w_inv[7]}
           ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]}
           ^ {w_inv[3:0], w_inv[7:4]}
           ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_scheduler.sv
// -----------------------------------------------------------------------------
// aes_key_scheduler
// Word-serial AES-128 key expansion (one shared S-box, fixed 80-cycle
// schedule) with a 44x32 round-key store served to an encrypt and a decrypt
// requester under round-robin arbitration.
//   clk, rst                  clock, async active-low reset
//   key_in/key_valid/key_ready 128-bit cipher key load handshake
//   keys_valid                store holds a complete schedule
//   enc_req/enc_round         encrypt requester, round 0..10
//   dec_req/dec_round         decrypt requester, round 0..10
//   enc_gnt/dec_gnt           one-cycle grant pulses
//   rk_data/rk_valid/rk_id    served round key, valid pulse, requester id
//   rk_err                    requested round index out of range
// -----------------------------------------------------------------------------
module aes_key_scheduler #(
  parameter int NR         = 10,
  parameter bit FIRST_PRIO = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic         keys_valid,
  input  logic         enc_req,
  input  logic         dec_req,
  input  logic [3:0]   enc_round,
  input  logic [3:0]   dec_round,
  output logic         enc_gnt,
  output logic         dec_gnt,
  output logic [127:0] rk_data,
  output logic         rk_valid,
  output logic         rk_id,
  output logic         rk_err
);
  import aes_key_scheduler_pkg::*;

  localparam logic [3:0] MAX_ROUND = 4'(NR);
  localparam logic [5:0] LAST_IDX  = 6'(NW - 1);
  localparam logic [5:0] FIRST_EXP = 6'(NK);

  state_t        r_state;
  logic [31:0]   r_w [0:NW-1];
  logic [5:0]    r_idx;
  logic [1:0]    r_sub;
  logic          r_sub_phase;
  logic [31:0]   r_temp;
  logic [7:0]    r_rcon;
  logic          r_last;
  logic          r_key_ready, r_keys_valid, r_enc_gnt, r_dec_gnt;
  logic [127:0]  r_rk_data;
  logic          r_rk_valid, r_rk_id, r_rk_err;

  logic          w_load, w_serve, w_gnt_enc, w_gnt_dec, w_round_ok;
  logic [31:0]   w_prev, w_back, w_rot, w_new;
  logic [7:0]    w_sbox_in, w_sbox_out;
  logic [3:0]    w_round;
  logic [5:0]    w_base;
  logic [127:0]  w_rk;

  aes_sbox u_sbox (
    .i_byte (w_sbox_in),
    .o_byte (w_sbox_out)
  );

  // Expansion datapath, arbitration decision and round-key read mux.
  always_comb begin
    w_load    = key_valid & r_key_ready;
    w_prev    = r_w[r_idx - 6'd1];
    w_back    = r_w[r_idx - 6'd4];
    w_rot     = {w_prev[23:0], w_prev[31:24]};
    case (r_sub)
      2'd0:    w_sbox_in = w_rot[31:24];
      2'd1:    w_sbox_in = w_rot[23:16];
      2'd2:    w_sbox_in = w_rot[15:8];
      2'd3:    w_sbox_in = w_rot[7:0];
      default: w_sbox_in = 8'h00;
    endcase
    if (r_idx[1:0] == 2'b00) begin
      w_new = w_back ^ r_temp ^ {r_rcon, 24'h000000};
    end else begin
      w_new = w_back ^ w_prev;
    end
    // A load in READY takes the cycle; no grant alongside it.
    w_serve   = (r_state == ST_READY) && !w_load;
    w_gnt_enc = w_serve && enc_req && (!dec_req || (r_last == DEC));
    w_gnt_dec = w_serve && dec_req && (!enc_req || (r_last == ENC));
    w_round   = w_gnt_dec ? dec_round : enc_round;
    w_round_ok = (w_round <= MAX_ROUND);
    // Out-of-range rounds read a safe address; the data is zeroed anyway.
    w_base    = w_round_ok ? {w_round, 2'b00} : 6'd0;
    w_rk      = {r_w[w_base], r_w[w_base + 6'd1], r_w[w_base + 6'd2], r_w[w_base + 6'd3]};
  end

  // Round-key store: key words on load, one expanded word per WRITE cycle.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_w[0] <= key_in[127:96];
      r_w[1] <= key_in[95:64];
      r_w[2] <= key_in[63:32];
      r_w[3] <= key_in[31:0];
    end else if ((r_state == ST_EXP) && !r_sub_phase) begin
      r_w[r_idx] <= w_new;
    end
  end

  // Control FSM, expansion sequencing, arbiter state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= 6'd0;
      r_sub        <= 2'd0;
      r_sub_phase  <= 1'b0;
      r_temp       <= 32'h0;
      r_rcon       <= RCON_INIT;
      r_last       <= !FIRST_PRIO;
      r_key_ready  <= 1'b1;
      r_keys_valid <= 1'b0;
      r_enc_gnt    <= 1'b0;
      r_dec_gnt    <= 1'b0;
      r_rk_data    <= 128'h0;
      r_rk_valid   <= 1'b0;
      r_rk_id      <= 1'b0;
      r_rk_err     <= 1'b0;
    end else begin
      r_enc_gnt  <= w_gnt_enc;
      r_dec_gnt  <= w_gnt_dec;
      r_rk_valid <= w_gnt_enc | w_gnt_dec;
      if (w_gnt_enc | w_gnt_dec) begin
        r_rk_id   <= w_gnt_dec;
        r_rk_err  <= !w_round_ok;
        r_rk_data <= w_round_ok ? w_rk : 128'h0;
        r_last    <= w_gnt_dec;
      end else begin
        r_rk_err  <= 1'b0;
      end
      case (r_state)
        ST_IDLE, ST_READY: begin
          if (w_load) begin
            r_state      <= ST_EXP;
            r_idx        <= FIRST_EXP;
            r_rcon       <= RCON_INIT;
            r_sub        <= 2'd0;
            r_sub_phase  <= 1'b1;
            r_key_ready  <= 1'b0;
            r_keys_valid <= 1'b0;
          end
        end
        ST_EXP: begin
          if (r_sub_phase) begin
            case (r_sub)
              2'd0:    r_temp[31:24] <= w_sbox_out;
              2'd1:    r_temp[23:16] <= w_sbox_out;
              2'd2:    r_temp[15:8]  <= w_sbox_out;
              2'd3:    r_temp[7:0]   <= w_sbox_out;
              default: r_temp        <= r_temp;
            endcase
            r_sub <= r_sub + 2'd1;
            if (r_sub == 2'd3) begin
              r_sub_phase <= 1'b0;
            end
          end else begin
            if (r_idx[1:0] == 2'b00) begin
              r_rcon <= xtime(r_rcon);
            end
            if (r_idx == LAST_IDX) begin
              r_state      <= ST_READY;
              r_key_ready  <= 1'b1;
              r_keys_valid <= 1'b1;
            end else begin
              r_idx <= r_idx + 6'd1;
              // Next word starts a new round: run the four SUB cycles first.
              if (r_idx[1:0] == 2'b11) begin
                r_sub_phase <= 1'b1;
                r_sub       <= 2'd0;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign key_ready  = r_key_ready;
  assign keys_valid = r_keys_valid;
  assign enc_gnt    = r_enc_gnt;
  assign dec_gnt    = r_dec_gnt;
  assign rk_data    = r_rk_data;
  assign rk_valid   = r_rk_valid;
  assign rk_id      = r_rk_id;
  assign rk_err     = r_rk_err;

endmodule

// File: tb/tb_aes_key_scheduler.sv
// -----------------------------------------------------------------------------
// tb_aes_key_scheduler
// Directed self-checking bench for aes_key_scheduler using FIPS-197 vectors.
// -----------------------------------------------------------------------------
module tb_aes_key_scheduler;

  localparam logic [127:0] K1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K1_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K1_R3  = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam logic [127:0] K1_R7  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
  localparam logic [127:0] K1_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K2_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [127:0] key_in = 128'h0;
  logic         key_valid = 1'b0;
  logic         key_ready, keys_valid;
  logic         enc_req = 1'b0, dec_req = 1'b0;
  logic [3:0]   enc_round = 4'd0, dec_round = 4'd0;
  logic         enc_gnt, dec_gnt;
  logic [127:0] rk_data;
  logic         rk_valid, rk_id, rk_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  aes_key_scheduler #(.NR(10), .FIRST_PRIO(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .keys_valid (keys_valid),
    .enc_req    (enc_req),
    .dec_req    (dec_req),
    .enc_round  (enc_round),
    .dec_round  (dec_round),
    .enc_gnt    (enc_gnt),
    .dec_gnt    (dec_gnt),
    .rk_data    (rk_data),
    .rk_valid   (rk_valid),
    .rk_id      (rk_id),
    .rk_err     (rk_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until keys_valid rises (bounded); reports edges taken and any grant seen.
  task automatic run_expansion(output int n, output bit gnt_seen);
    n = 0;
    gnt_seen = 1'b0;
    while (n < 200) begin
      step();
      n++;
      if (enc_gnt || dec_gnt) gnt_seen = 1'b1;
      if (keys_valid) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    n_vec++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL reset_key_ready got %0b want 1", key_ready); end
    n_vec++; if (keys_valid !== 1'b0) begin n_err++; $display("FAIL reset_keys_valid got %0b want 0", keys_valid); end
    n_vec++; if ({enc_gnt, dec_gnt, rk_valid, rk_err, rk_id} !== 5'b00000) begin n_err++; $display("FAIL reset_flags got %b want 00000", {enc_gnt, dec_gnt, rk_valid, rk_err, rk_id}); end
    n_vec++; if (rk_data !== 128'h0) begin n_err++; $display("FAIL reset_rk_data got %h want 0", rk_data); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_fips_load();
    int n;
    bit g;
    key_in = K1;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    n_vec++; if (key_ready !== 1'b0) begin n_err++; $display("FAIL load_key_ready got %0b want 0", key_ready); end
    run_expansion(n, g);
    n_vec++; if (n !== 80) begin n_err++; $display("FAIL exp_latency got %0d want 80", n); end
    n_vec++; if (key_ready !== 1'b1) begin n_err++; $display("FAIL exp_done_key_ready got %0b want 1", key_ready); end
  endtask

  task automatic test_contention();
    logic want_dec;
    enc_req = 1'b1; enc_round = 4'd3;
    dec_req = 1'b1; dec_round = 4'd7;
    for (int i = 0; i < 4; i++) begin
      step();
      want_dec = (i % 2 == 1);
      n_vec++; if ({enc_gnt, dec_gnt} !== {~want_dec, want_dec}) begin n_err++; $display("FAIL contend_gnt[%0d] got %b want %b", i, {enc_gnt, dec_gnt}, {~want_dec, want_dec}); end
      n_vec++; if ({rk_valid, rk_id} !== {1'b1, want_dec}) begin n_err++; $display("FAIL contend_id[%0d] got %b want %b", i, {rk_valid, rk_id}, {1'b1, want_dec}); end
      n_vec++; if (rk_data !== (want_dec ? K1_R7 : K1_R3)) begin n_err++; $display("FAIL contend_data[%0d] got %h want %h", i, rk_data, want_dec ? K1_R7 : K1_R3); end
    end
    enc_req = 1'b0;
    dec_req = 1'b0;
    step();
    n_vec++; if ({enc_gnt, dec_gnt, rk_valid} !== 3'b000) begin n_err++; $display("FAIL contend_idle got %b want 000", {enc_gnt, dec_gnt, rk_valid}); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]   rnd [3];
    logic [127:0] exp_k [3];
    rnd[0] = 4'd1;  exp_k[0] = K1_R1;
    rnd[1] = 4'd10; exp_k[1] = K1_R10;
    rnd[2] = 4'd0;  exp_k[2] = K1;
    for (int i = 0; i < 3; i++) begin
      enc_round = rnd[i];
      enc_req = 1'b1;
      step();
      enc_req = 1'b0;
      n_vec++; if ({enc_gnt, dec_gnt, rk_valid, rk_id, rk_err} !== 5'b10100) begin n_err++; $display("FAIL b2b_flags[r%0d] got %b want 10100", rnd[i], {enc_gnt, dec_gnt, rk_valid, rk_id, rk_err}); end
      n_vec++; if (rk_data !== exp_k[i]) begin n_err++; $display("FAIL b2b_data[r%0d] got %h want %h", rnd[i], rk_data, exp_k[i]); end
    end
  endtask

  task automatic test_bad_index();
    dec_round = 4'd11;
    dec_req = 1'b1;
    step();
    dec_req = 1'b0;
    n_vec++; if ({enc_gnt, dec_gnt, rk_valid, rk_id, rk_err} !== 5'b01111) begin n_err++; $display("FAIL bad_flags got %b want 01111", {enc_gnt, dec_gnt, rk_valid, rk_id, rk_err}); end
    n_vec++; if (rk_data !== 128'h0) begin n_err++; $display("FAIL bad_data got %h want 0", rk_data); end
    step();
    n_vec++; if ({rk_valid, rk_err} !== 2'b00) begin n_err++; $display("FAIL bad_clear got %b want 00", {rk_valid, rk_err}); end
  endtask

  task automatic test_reload_with_request();
    int n;
    bit g;
    key_in = K2;
    key_valid = 1'b1;
    enc_round = 4'd10;
    enc_req = 1'b1;
    step();
    key_valid = 1'b0;
    n_vec++; if ({enc_gnt, rk_valid, key_ready, keys_valid} !== 4'b0000) begin n_err++; $display("FAIL reload_no_gnt got %b want 0000", {enc_gnt, rk_valid, key_ready, keys_valid}); end
    run_expansion(n, g);
    n_vec++; if (n !== 80) begin n_err++; $display("FAIL reload_latency got %0d want 80", n); end
    n_vec++; if (g !== 1'b0) begin n_err++; $display("FAIL held_req_early_gnt got %0b want 0", g); end
    step();
    enc_req = 1'b0;
    n_vec++; if ({enc_gnt, rk_valid, rk_id, rk_err} !== 4'b1100) begin n_err++; $display("FAIL held_req_gnt got %b want 1100", {enc_gnt, rk_valid, rk_id, rk_err}); end
    n_vec++; if (rk_data !== K2_R10) begin n_err++; $display("FAIL key2_r10 got %h want %h", rk_data, K2_R10); end
  endtask

  task automatic test_reset_mid_expansion();
    int n;
    bit g;
    key_in = K1;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    repeat (40) step();
    rst = 1'b0;
    #1;
    n_vec++; if ({key_ready, keys_valid, enc_gnt, dec_gnt, rk_valid, rk_err, rk_id} !== 7'b1000000) begin n_err++; $display("FAIL midrst_flags got %b want 1000000", {key_ready, keys_valid, enc_gnt, dec_gnt, rk_valid, rk_err, rk_id}); end
    n_vec++; if (rk_data !== 128'h0) begin n_err++; $display("FAIL midrst_data got %h want 0", rk_data); end
    #1;
    rst = 1'b1;
    key_valid = 1'b1;
    step();
    key_valid = 1'b0;
    run_expansion(n, g);
    n_vec++; if (n !== 80) begin n_err++; $display("FAIL midrst_latency got %0d want 80", n); end
    dec_round = 4'd10;
    dec_req = 1'b1;
    step();
    dec_req = 1'b0;
    n_vec++; if ({dec_gnt, rk_valid, rk_id, rk_err} !== 4'b1110) begin n_err++; $display("FAIL midrst_gnt got %b want 1110", {dec_gnt, rk_valid, rk_id, rk_err}); end
    n_vec++; if (rk_data !== K1_R10) begin n_err++; $display("FAIL midrst_r10 got %h want %h", rk_data, K1_R10); end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fips_load();
    test_contention();
    test_back_to_back();
    test_bad_index();
    test_reload_with_request();
    test_reset_mid_expansion();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
